ring_addr_gen: RTL and testbench

- Address/round-count generator for the circular event buffer. It sits directly upstream of the memory usage monitor.
- It tracks write and read pointers over a ring of programmable length `limit`.
- It produces `wr_addr`, `rd_addr`, the write round count (n1) and the read round count (n2) consumed by the monitor, plus the memory write strobe and read strobe.
- It enforces full/empty itself and flags rejected requests.

---
 rtl/ring_buf_pkg.sv | 17 +
 rtl/ring_ptr.sv | 44 ++++
 rtl/ring_addr_gen.sv | 134 +++++++++++++
 tb/tb_ring_addr_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ring_buf_pkg.sv
// Shared constants and types for the circular event buffer (address generator and usage monitor).
package ring_buf_pkg;

    localparam int unsigned AW        = 18;
    localparam int unsigned RW        = 16;
    localparam int unsigned MIN_LIMIT = 2;

    typedef logic [AW-1:0] addr_t;
    typedef logic [RW-1:0] round_t;
    typedef logic [AW:0]   occ_t;

    // A ring shorter than MIN_LIMIT words cannot distinguish full from empty by pointer alone.
    function automatic addr_t clamp_limit(input addr_t lim);
        return (lim < AW'(MIN_LIMIT)) ? AW'(MIN_LIMIT) : lim;
    endfunction

endpackage

// File: rtl/ring_ptr.sv
// One ring pointer with its wrap-round counter; used for both the write and the read side.
module ring_ptr
    import ring_buf_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    input  logic [AW-1:0] limit_q,
    output logic [AW-1:0] ptr,
    output logic [RW-1:0] rounds
);

    addr_t  ptr_q, ptr_d;
    round_t rounds_q, rounds_d;
    logic   at_end;

    always_comb begin
        ptr_d    = ptr_q;
        rounds_d = rounds_q;
        at_end   = (ptr_q == limit_q - AW'(1));
        if (adv) begin
            if (at_end) begin
                ptr_d    = '0;
                rounds_d = rounds_q + RW'(1);
            end else begin
                ptr_d    = ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q    <= '0;
            rounds_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rounds_q <= rounds_d;
        end
    end

    assign ptr    = ptr_q;
    assign rounds = rounds_q;

endmodule

// File: rtl/ring_addr_gen.sv
// Write/read address and round-count generator for the circular event buffer.
// Optional almost-full output enabled by defining RING_ALMOST_FULL_EN.
module ring_addr_gen
    import ring_buf_pkg::*;
#(
    parameter int unsigned AF_MARGIN = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] limit,
    input  logic          wr_en,
    input  logic          rd_req,
    input  logic          clr_err,
    output logic          mem_we,
    output logic          mem_re,
    output logic          rd_valid,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [RW-1:0] n_wr_rounds,
    output logic [RW-1:0] n_rd_rounds,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          overflow,
    output logic          underflow
);

    addr_t limit_q, limit_d;
    occ_t  occ_q, occ_d;
    logic  full_q, full_d;
    logic  empty_q, empty_d;
    logic  overflow_q, overflow_d;
    logic  underflow_q, underflow_d;
    logic  rd_valid_q, rd_valid_d;
    logic  wr_ok, rd_ok;

    // Strobes are held off while reset is asserted so no stale access reaches the RAM.
    always_comb begin
        wr_ok       = wr_en  & ~full_q  & reset;
        rd_ok       = rd_req & ~empty_q & reset;
        limit_d     = reset ? limit_q : clamp_limit(limit);
        occ_d       = occ_q;
        if (wr_ok && !rd_ok) begin
            occ_d = occ_q + (AW+1)'(1);
        end else if (rd_ok && !wr_ok) begin
            occ_d = occ_q - (AW+1)'(1);
        end
        full_d      = (occ_d == {1'b0, limit_q});
        empty_d     = (occ_d == '0);
        overflow_d  = (wr_en  & full_q)  | (overflow_q  & ~clr_err);
        underflow_d = (rd_req & empty_q) | (underflow_q & ~clr_err);
        rd_valid_d  = rd_ok;
    end

    always_ff @(posedge clk) begin
        limit_q <= limit_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ_q       <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    ring_ptr u_wr_ptr (
        .clk     (clk),
        .reset   (reset),
        .adv     (wr_ok),
        .limit_q (limit_q),
        .ptr     (wr_addr),
        .rounds  (n_wr_rounds)
    );

    ring_ptr u_rd_ptr (
        .clk     (clk),
        .reset   (reset),
        .adv     (rd_ok),
        .limit_q (limit_q),
        .ptr     (rd_addr),
        .rounds  (n_rd_rounds)
    );

`ifdef RING_ALMOST_FULL_EN
    localparam logic [AW:0] AF_M = (AW+1)'(AF_MARGIN);

    logic almost_full_q, almost_full_d;

    // A margin covering the whole ring degenerates to "anything buffered".
    always_comb begin
        almost_full_d = 1'b0;
        if (AF_M >= {1'b0, limit_q}) begin
            almost_full_d = (occ_d != '0);
        end else begin
            almost_full_d = (occ_d >= ({1'b0, limit_q} - AF_M));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign almost_full = almost_full_q;
`else
    // The margin is only consumed by the almost-full comparator.
    if (AF_MARGIN != 0) begin : g_af_margin_unused
    end
    assign almost_full = 1'b0;
`endif

    assign mem_we    = wr_ok;
    assign mem_re    = rd_ok;
    assign rd_valid  = rd_valid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_ring_addr_gen.sv
// Directed bench for ring_addr_gen: vector table for fill/drain at limit 8, plus corner sequences.
module tb_ring_addr_gen;
    import ring_buf_pkg::*;

`ifdef RING_ALMOST_FULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] limit;
    logic          wr_en, rd_req, clr_err;
    logic          mem_we, mem_re, rd_valid;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [RW-1:0] n_wr_rounds, n_rd_rounds;
    logic          full, empty, almost_full, overflow, underflow;

    ring_addr_gen #(.AF_MARGIN(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .limit       (limit),
        .wr_en       (wr_en),
        .rd_req      (rd_req),
        .clr_err     (clr_err),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .rd_valid    (rd_valid),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .n_wr_rounds (n_wr_rounds),
        .n_rd_rounds (n_rd_rounds),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit wr, rd, clr;
        bit exp_we, exp_re;
        int exp_wa, exp_ra, exp_nw, exp_nr;
        bit exp_full, exp_empty, exp_ovf, exp_unf, exp_rdv;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic we_s, re_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit w, input bit r, input bit c, input bit we, input bit re,
                       input int wa, input int ra, input int nw, input int nr,
                       input bit f, input bit e, input bit o, input bit u, input bit v);
        vec_t x;
        x.wr = w; x.rd = r; x.clr = c; x.exp_we = we; x.exp_re = re;
        x.exp_wa = wa; x.exp_ra = ra; x.exp_nw = nw; x.exp_nr = nr;
        x.exp_full = f; x.exp_empty = e; x.exp_ovf = o; x.exp_unf = u; x.exp_rdv = v;
        vecs.push_back(x);
    endtask

    // Called at a negedge; leaves the bench at the next negedge with reset released.
    task automatic do_reset(input int lim);
        reset = 1'b0; limit = AW'(lim);
        wr_en = 1'b0; rd_req = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Drive one cycle from a negedge, capture the strobes, and return at the next negedge.
    task automatic step(input bit w, input bit r, input bit c);
        wr_en = w; rd_req = r; clr_err = c;
        #1;
        we_s = mem_we; re_s = mem_re;
        @(negedge clk);
        wr_en = 1'b0; rd_req = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        int wa, ra, nw, nr;
        reset = 1'b0; limit = '0; wr_en = 1'b0; rd_req = 1'b0; clr_err = 1'b0;

        for (int k = 1; k <= 8; k++)
            add(1,0,0, 1,0, k % 8, 0, (k == 8), 0, (k == 8), 0, 0, 0, 0);
        add(1,0,0, 0,0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(0,1,0, 0,1, 0, k % 8, 1, (k == 8), 0, (k == 8), 1, 0, 1);
        add(0,1,0, 0,0, 0, 0, 1, 1, 0, 1, 1, 1, 0);
        add(0,1,1, 0,0, 0, 0, 1, 1, 0, 1, 0, 1, 0);
        add(0,0,1, 0,0, 0, 0, 1, 1, 0, 1, 0, 0, 0);

        @(negedge clk);
        do_reset(8);
        @(negedge clk);
        chk("rst_wa", 32'(wr_addr), 0);
        chk("rst_ra", 32'(rd_addr), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_rdv", 32'(rd_valid), 0);
        chk("rst_af", 32'(almost_full), 0);

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].clr);
            chk($sformatf("v%0d_we", i), 32'(we_s), 32'(vecs[i].exp_we));
            chk($sformatf("v%0d_re", i), 32'(re_s), 32'(vecs[i].exp_re));
            chk($sformatf("v%0d_wa", i), 32'(wr_addr), vecs[i].exp_wa);
            chk($sformatf("v%0d_ra", i), 32'(rd_addr), vecs[i].exp_ra);
            chk($sformatf("v%0d_nw", i), 32'(n_wr_rounds), vecs[i].exp_nw);
            chk($sformatf("v%0d_nr", i), 32'(n_rd_rounds), vecs[i].exp_nr);
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            chk($sformatf("v%0d_unf", i), 32'(underflow), 32'(vecs[i].exp_unf));
            chk($sformatf("v%0d_rdv", i), 32'(rd_valid), 32'(vecs[i].exp_rdv));
        end

        // limit 5, steady state at occupancy 1; limit input changed after reset must be ignored
        do_reset(5);
        limit = AW'(9);
        step(1,0,0);
        wa = 1; ra = 0; nw = 0; nr = 0;
        for (int c = 0; c < 23; c++) begin
            step(1,1,0);
            wa = (wa + 1) % 5; if (wa == 0) nw++;
            ra = (ra + 1) % 5; if (ra == 0) nr++;
            chk($sformatf("ss%0d_we", c), 32'(we_s), 1);
            chk($sformatf("ss%0d_re", c), 32'(re_s), 1);
            chk($sformatf("ss%0d_wa", c), 32'(wr_addr), wa);
            chk($sformatf("ss%0d_ra", c), 32'(rd_addr), ra);
            chk($sformatf("ss%0d_nw", c), 32'(n_wr_rounds), nw);
            chk($sformatf("ss%0d_nr", c), 32'(n_rd_rounds), nr);
            chk($sformatf("ss%0d_lead", c), (32'(wr_addr) + 5 - 32'(rd_addr)) % 5, 1);
            chk($sformatf("ss%0d_rdiff", c), 32'((n_wr_rounds - n_rd_rounds) <= RW'(1)), 1);
            chk($sformatf("ss%0d_fe", c), 32'({full, empty}), 0);
        end

        // full + both: read taken, write rejected, occupancy limit-1
        do_reset(4);
        for (int k = 0; k < 4; k++) step(1,0,0);
        chk("fb_full0", 32'(full), 1);
        step(1,1,0);
        chk("fb_we", 32'(we_s), 0);
        chk("fb_re", 32'(re_s), 1);
        chk("fb_full", 32'(full), 0);
        chk("fb_ovf", 32'(overflow), 1);
        chk("fb_wa", 32'(wr_addr), 0);
        chk("fb_ra", 32'(rd_addr), 1);
        for (int k = 1; k <= 3; k++) begin
            step(0,1,0);
            chk($sformatf("fb_drain%0d_empty", k), 32'(empty), 32'(k == 3));
        end
        chk("fb_nr", 32'(n_rd_rounds), 1);

        // empty + both: write taken, read rejected
        do_reset(4);
        step(1,1,0);
        chk("eb_we", 32'(we_s), 1);
        chk("eb_re", 32'(re_s), 0);
        chk("eb_unf", 32'(underflow), 1);
        chk("eb_wa", 32'(wr_addr), 1);
        chk("eb_ra", 32'(rd_addr), 0);
        chk("eb_empty", 32'(empty), 0);
        chk("eb_rdv", 32'(rd_valid), 0);

        // limit 1 clamps to 2
        do_reset(1);
        step(1,0,0);
        chk("l1_full1", 32'(full), 0);
        chk("l1_wa1", 32'(wr_addr), 1);
        step(1,0,0);
        chk("l1_full2", 32'(full), 1);
        chk("l1_wa2", 32'(wr_addr), 0);
        chk("l1_nw", 32'(n_wr_rounds), 1);

        // reset mid-burst at occupancy 3 with a read in flight
        do_reset(8);
        for (int k = 0; k < 3; k++) step(1,0,0);
        wr_en = 1'b1; rd_req = 1'b1;
        #1;
        chk("mr_re_pre", 32'(mem_re), 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_we_in_rst", 32'(mem_we), 0);
        chk("mr_re_in_rst", 32'(mem_re), 0);
        @(negedge clk);
        chk("mr_wa", 32'(wr_addr), 0);
        chk("mr_ra", 32'(rd_addr), 0);
        chk("mr_rounds", 32'({n_wr_rounds, n_rd_rounds}), 0);
        chk("mr_flags", 32'({full, overflow, underflow, almost_full}), 0);
        chk("mr_empty", 32'(empty), 1);
        chk("mr_rdv", 32'(rd_valid), 0);
        reset = 1'b1; wr_en = 1'b0; rd_req = 1'b0;
        @(negedge clk);

        // almost-full threshold at limit 64, margin 16
        do_reset(64);
        for (int k = 1; k <= 48; k++) begin
            step(1,0,0);
            chk($sformatf("af_w%0d", k), 32'(almost_full), 32'(AF_EN && (k >= 48)));
        end
        step(0,1,0);
        chk("af_fall47", 32'(almost_full), 0);
        step(1,0,0);
        chk("af_rise48", 32'(almost_full), 32'(AF_EN));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
